// File: rtl/seq_gen.sv
// seq_gen: serialises a latched word MSB-first, repeat_cnt+1 times back to
// back, then pulses done for one cycle. While the stream is emitted, a 4-bit
// window of the emitted bits is tracked across word boundaries, and every
// 1101 or 0110 window is counted in a saturating 8-bit match counter.
// All outputs come straight from flops, so dout only moves on the rising edge.
module seq_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [7:0]       repeat_cnt,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             done,
  output logic [7:0]       match_cnt
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Registered state
  state_t           r_state;
  logic [WIDTH-1:0] r_word;     // latched word being serialised
  logic [7:0]       r_rep;      // words still to send after the current one
  logic [IDXW-1:0]  r_idx;      // index of the bit currently on dout
  logic             r_ready;
  logic             r_dout;
  logic             r_valid;
  logic             r_done;
  logic [3:0]       r_window;   // last four emitted bits, oldest in [3]
  logic [1:0]       r_fill;     // emitted bits so far, saturating at 3
  logic [7:0]       r_match;

  // Next-state values
  state_t           w_state_next;
  logic [WIDTH-1:0] w_word_next;
  logic [7:0]       w_rep_next;
  logic [IDXW-1:0]  w_idx_next;
  logic             w_ready_next;
  logic             w_dout_next;
  logic             w_valid_next;
  logic             w_done_next;
  logic [3:0]       w_window_next;
  logic [1:0]       w_fill_next;
  logic [7:0]       w_match_next;

  // Emission helpers: a bit is emitted on this edge, and the window/counter
  // values it builds on (cleared on a fresh acceptance).
  logic             w_emit;
  logic             w_emit_bit;
  logic [3:0]       w_win_base;
  logic [1:0]       w_fill_base;
  logic [7:0]       w_match_base;
  logic [IDXW-1:0]  w_idx_dec;
  logic             w_hit;

  assign w_idx_dec = r_idx - IDXW'(1);

  assign ready      = r_ready;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign done       = r_done;
  assign match_cnt  = r_match;

  // Next-state, emission and pattern-count logic
  always_comb begin
    w_state_next  = r_state;
    w_word_next   = r_word;
    w_rep_next    = r_rep;
    w_idx_next    = r_idx;
    w_ready_next  = r_ready;
    w_dout_next   = r_dout;
    w_valid_next  = r_valid;
    w_done_next   = r_done;
    w_emit        = 1'b0;
    w_emit_bit    = 1'b0;
    w_win_base    = r_window;
    w_fill_base   = r_fill;
    w_match_base  = r_match;
    w_window_next = r_window;
    w_fill_next   = r_fill;
    w_match_next  = r_match;
    w_hit         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready_next = 1'b1;
        w_dout_next  = 1'b0;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
        if (load) begin
          // Accept: latch the request and put the first bit out immediately.
          w_word_next  = data;
          w_rep_next   = repeat_cnt;
          w_idx_next   = LAST_IDX;
          w_emit       = 1'b1;
          w_emit_bit   = data[WIDTH-1];
          w_win_base   = 4'd0;
          w_fill_base  = 2'd0;
          w_match_base = 8'd0;
          w_ready_next = 1'b0;
          w_state_next = S_SHIFT;
        end
      end

      S_SHIFT: begin
        w_ready_next = 1'b0;
        w_done_next  = 1'b0;
        if (r_idx != '0) begin
          w_idx_next = w_idx_dec;
          w_emit     = 1'b1;
          w_emit_bit = r_word[w_idx_dec];
        end else if (r_rep != 8'd0) begin
          // Start the next repeat with no gap.
          w_rep_next = r_rep - 8'd1;
          w_idx_next = LAST_IDX;
          w_emit     = 1'b1;
          w_emit_bit = r_word[WIDTH-1];
        end else begin
          w_dout_next  = 1'b0;
          w_valid_next = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_ready_next = 1'b1;
        w_dout_next  = 1'b0;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
        w_state_next = S_IDLE;
      end

      default: begin
        // Unreachable encoding: fall back to a clean idle.
        w_ready_next = 1'b1;
        w_dout_next  = 1'b0;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase

    if (w_emit) begin
      w_dout_next   = w_emit_bit;
      w_valid_next  = 1'b1;
      w_window_next = {w_win_base[2:0], w_emit_bit};
      w_fill_next   = (w_fill_base == 2'd3) ? 2'd3 : w_fill_base + 2'd1;
      w_match_next  = w_match_base;
      // The window is complete only once three earlier bits exist.
      w_hit = (w_fill_base == 2'd3) &&
              ((w_window_next == 4'b1101) || (w_window_next == 4'b0110));
      if (w_hit && (w_match_base != 8'hFF)) begin
        w_match_next = w_match_base + 8'd1;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_word   <= '0;
      r_rep    <= 8'd0;
      r_idx    <= '0;
      r_ready  <= 1'b1;
      r_dout   <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_window <= 4'd0;
      r_fill   <= 2'd0;
      r_match  <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_word   <= w_word_next;
      r_rep    <= w_rep_next;
      r_idx    <= w_idx_next;
      r_ready  <= w_ready_next;
      r_dout   <= w_dout_next;
      r_valid  <= w_valid_next;
      r_done   <= w_done_next;
      r_window <= w_window_next;
      r_fill   <= w_fill_next;
      r_match  <= w_match_next;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen (WIDTH=8): a timeline model predicts every output on every
// cycle, and directed tests pin key values with hand-computed literals.
module tb_seq_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] data = '0;
  logic [7:0]   repeat_cnt = 8'd0;
  logic         ready;
  logic         dout;
  logic         dout_valid;
  logic         done;
  logic [7:0]   match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  seq_gen #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .repeat_cnt (repeat_cnt),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .done       (done),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s at t=%0t: actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // On acceptance the whole expected timeline is generated from the word and
  // repeat count; each edge pops one cycle of expected outputs.
  typedef struct {
    logic rdy;
    logic bitv;
    logic vld;
    logic dn;
    int   mcnt;
  } exp_t;

  exp_t cur;
  exp_t tl[$];
  int   held_match = 0;
  bit   started = 1'b0;

  function automatic void build(input logic [7:0] d, input logic [7:0] r);
    logic bits[$];
    exp_t e;
    int   cnt = 0;
    for (int w = 0; w <= int'(r); w++)
      for (int b = W - 1; b >= 0; b--)
        bits.push_back(d[b]);
    for (int j = 0; j < bits.size(); j++) begin
      if (j >= 3) begin
        logic [3:0] win;
        win = {bits[j-3], bits[j-2], bits[j-1], bits[j]};
        if ((win == 4'b1101 || win == 4'b0110) && cnt < 255) cnt++;
      end
      e.rdy = 1'b0; e.bitv = bits[j]; e.vld = 1'b1; e.dn = 1'b0; e.mcnt = cnt;
      tl.push_back(e);
    end
    e.rdy = 1'b0; e.bitv = 1'b0; e.vld = 1'b0; e.dn = 1'b1; e.mcnt = cnt;
    tl.push_back(e);
    held_match = cnt;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      tl.delete();
      held_match = 0;
      cur.rdy = 1'b1; cur.bitv = 1'b0; cur.vld = 1'b0; cur.dn = 1'b0; cur.mcnt = 0;
      started = 1'b1;
    end else if (started) begin
      if (cur.rdy && load) build(data, repeat_cnt);
      if (tl.size() > 0) begin
        cur = tl.pop_front();
      end else begin
        cur.rdy = 1'b1; cur.bitv = 1'b0; cur.vld = 1'b0; cur.dn = 1'b0; cur.mcnt = held_match;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("model_ready",      int'(ready),      int'(cur.rdy));
      chk("model_dout",       int'(dout),       int'(cur.bitv));
      chk("model_dout_valid", int'(dout_valid), int'(cur.vld));
      chk("model_done",       int'(done),       int'(cur.dn));
      chk("model_match_cnt",  int'(match_cnt),  cur.mcnt);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one transmission, scramble inputs afterwards, and record the first
  // 16 bits, the cycle of done and match_cnt at done (cycle 1 = after accept).
  task automatic send(input logic [7:0] d, input logic [7:0] r,
                      output logic [15:0] first_bits, output int done_cyc,
                      output int match_at_done);
    data = d; repeat_cnt = r; load = 1'b1;
    tick();
    load = 1'b0;
    data = 8'($urandom);
    repeat_cnt = 8'($urandom);
    first_bits = '0;
    done_cyc = -1;
    match_at_done = -1;
    for (int c = 1; c <= 2100 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (c <= 16) first_bits[16-c] = dout;
      if (done) begin
        done_cyc = c;
        match_at_done = int'(match_cnt);
      end
      tick();
    end
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("ready_after_done", int'(ready), 1);
    $display("tx data=%02h rep=%0d done_cycle=%0d match_cnt=%0d", d, r, done_cyc, match_at_done);
  endtask

  initial begin
    logic [15:0] fb;
    int          dc;
    int          mc;
    logic        cap[1:20];
    int          cnt;

    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", int'(ready), 1);
    chk("reset_dout", int'(dout), 0);
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_match", int'(match_cnt), 0);
    tick();

    // D6 once: 11010110, done at 9 with 2 matches
    send(8'hD6, 8'd0, fb, dc, mc);
    chk("d6_bits", int'(fb[15:8]), 8'hD6);
    chk("d6_done_cycle", dc, 9);
    chk("d6_match", mc, 2);
    tick();

    // DD twice: 16 contiguous bits, 4 matches
    send(8'hDD, 8'd1, fb, dc, mc);
    chk("dd2_bits", int'(fb), 16'hDDDD);
    chk("dd2_done_cycle", dc, 17);
    chk("dd2_match", mc, 4);
    // match_cnt holds while idle
    tick();
    @(negedge clk);
    chk("dd2_match_hold", int'(match_cnt), 4);
    tick();

    // DD 256 times: saturates at 255
    send(8'hDD, 8'd255, fb, dc, mc);
    chk("dd256_done_cycle", dc, 2049);
    chk("dd256_match_sat", mc, 255);
    tick();

    // 00 256 times: no matches
    send(8'h00, 8'd255, fb, dc, mc);
    chk("z256_done_cycle", dc, 2049);
    chk("z256_match", mc, 0);
    tick();

    // load held high, data changed mid-stream; second acceptance at edge 10
    data = 8'hD6; repeat_cnt = 8'd0; load = 1'b1;
    tick();
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      cap[c] = dout;
      tick();
      if (c == 2) data = 8'h6B;
      if (c == 10) load = 1'b0;
    end
    for (int j = 0; j < 8; j++) begin
      chk("held_first_d6", int'(cap[1+j]), (8'hD6 >> (7 - j)) & 1);
      chk("held_second_6b", int'(cap[11+j]), (8'h6B >> (7 - j)) & 1);
    end
    $display("tx held-load data=d6 then 6b");
    tick();

    // reset at cycle 4 of a D6 transmission
    data = 8'hD6; repeat_cnt = 8'd0; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", int'(dout_valid), 0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_match", int'(match_cnt), 0);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || dout_valid) cnt++;
    end
    chk("abort_no_done_or_bits", cnt, 0);
    $display("tx abort data=d6 reset at cycle 4");

    // reset and load together: nothing starts
    tick();
    data = 8'hFF; repeat_cnt = 8'd3; rst = 1'b1; load = 1'b1;
    tick();
    rst = 1'b0; load = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dout_valid || !ready) cnt++;
    end
    chk("rst_load_idle", cnt, 0);
    $display("tx rst+load data=ff ignored");

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
